// File: rtl/instruction_sequencer.sv
// instruction_sequencer: debounces the SPI instruction byte and executes each new one once
module instruction_sequencer #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TRIG_WIDTH     = 8,
  parameter int SRST_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic [7:0] mode,
  input  logic [7:0] trigger_channel_mask,
  input  logic       acq_done,
  output logic       acq_start,
  output logic [7:0] trig_out,
  output logic       soft_rst,
  output logic       busy,
  output logic [7:0] status_reg,
  output logic [7:0] cmd_count
);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, ACQ_START = 3'd1, ACQ_WAIT = 3'd2, TRIG = 3'd3, SRST = 3'd4} state_t;
  state_t state, state_n;
  logic [7:0] sync1, sync2, last_acc, mask_q;
  logic [SW-1:0] stable_cnt;
  logic [15:0] cnt;
  logic [6:0] op;
  logic cont, timeout_err, illegal_err, acc, is_stop, to_hit, unused_mode;
  assign unused_mode = ^mode[7:1];
  assign op = sync2[6:0];
  assign is_stop = op == 7'h05;
  // busy blocks everything but STOP; held values are re-checked once IDLE returns
  assign acc = stable_cnt == SMAX && sync2 != last_acc && (state == IDLE || is_stop);
  assign to_hit = state == ACQ_WAIT && !acq_done && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge iclk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (acc) state_n = op == 7'h01 ? ACQ_START : op == 7'h02 ? TRIG : op == 7'h03 ? SRST : IDLE;
      ACQ_START: state_n = ACQ_WAIT;
      ACQ_WAIT:  state_n = acq_done ? (cont ? ACQ_START : IDLE) : to_hit ? IDLE : ACQ_WAIT;
      TRIG:      if (cnt == 16'(TRIG_WIDTH - 1)) state_n = IDLE;
      SRST:      if (cnt == 16'(SRST_WIDTH - 1)) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (acc && is_stop) state_n = IDLE;
  end
  always_comb begin
    acq_start  = state == ACQ_START;
    soft_rst   = state == SRST;
    trig_out   = state == TRIG ? mask_q : 8'h00;
    busy       = state != IDLE;
    status_reg = {state, cont, illegal_err, timeout_err, state == ACQ_WAIT, state != IDLE};
  end
  always_ff @(posedge iclk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      stable_cnt  <= '0;
      last_acc    <= '0;
      mask_q      <= '0;
      cnt         <= '0;
      cont        <= 1'b0;
      timeout_err <= 1'b0;
      illegal_err <= 1'b0;
      cmd_count   <= '0;
    end else begin
      sync1      <= instruction;
      sync2      <= sync1;
      stable_cnt <= sync1 != sync2 ? '0 : stable_cnt == SMAX ? stable_cnt : stable_cnt + 1'b1;
      cnt        <= (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;
      if (acc) begin
        last_acc  <= sync2;
        cmd_count <= op == 7'h04 ? 8'h00 : cmd_count + 8'h01;
      end
      if (acc && state == IDLE && op == 7'h02) mask_q <= trigger_channel_mask;
      cont        <= (acc && is_stop) || to_hit ? 1'b0 : acc && state == IDLE && op == 7'h01 ? mode[0] : cont;
      timeout_err <= acc && op == 7'h04 ? 1'b0 : timeout_err | (to_hit && !(acc && is_stop));
      illegal_err <= acc && op == 7'h04 ? 1'b0 : illegal_err | (acc && op > 7'h05);
    end
  end
endmodule
